// File: rtl/axi_lite_master_rw.sv
// Single-outstanding AXI4-Lite master: turns one local command into a read or write burst-of-one,
// with independent AW/W tracking and a per-transaction watchdog. All outputs are registered.
module axi_lite_master_rw #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [2:0]              dbg_state
);

    // Handshakes: a transfer happens on the rising aclk edge where valid && ready are both high;
    // once raised, a valid (and its payload) is held until that edge.

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
    logic [SW-1:0]           wstrb_q, wstrb_n;
    logic                    aw_done, aw_done_n, w_done, w_done_n;
    logic [CW-1:0]           cnt, cnt_n, cnt_inc;
    logic                    expired, do_timeout;
    logic                    cmd_ready_n, awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic                    rsp_valid_n, rsp_timeout_n;
    logic [DATA_WIDTH-1:0]   rsp_rdata_n;
    logic [1:0]              rsp_resp_n;
    logic                    aw_hs, w_hs;

    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign dbg_state = state;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    // Saturates at the limit so a handshake that beats expiry never lets the count wrap.
    assign cnt_inc = (cnt == CW'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_n       = state;
        addr_n        = addr_q;
        wdata_n       = wdata_q;
        wstrb_n       = wstrb_q;
        aw_done_n     = aw_done;
        w_done_n      = w_done;
        cnt_n         = cnt;
        cmd_ready_n   = cmd_ready;
        awvalid_n     = awvalid;
        wvalid_n      = wvalid;
        bready_n      = bready;
        arvalid_n     = arvalid;
        rready_n      = rready;
        rsp_valid_n   = 1'b0;
        rsp_timeout_n = 1'b0;
        rsp_rdata_n   = '0;
        rsp_resp_n    = 2'b00;
        do_timeout    = 1'b0;

        if (state != IDLE) cnt_n = cnt_inc;

        case (state)
            IDLE: begin
                cmd_ready_n = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_n = 1'b0;
                    addr_n      = cmd_addr;
                    wdata_n     = cmd_wdata;
                    wstrb_n     = cmd_wstrb;
                    cnt_n       = '0;
                    if (cmd_write) begin
                        state_n   = WR;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n   = RD_ADDR;
                        arvalid_n = 1'b1;
                    end
                end
            end
            WR: begin
                if (aw_hs) begin
                    awvalid_n = 1'b0;
                    aw_done_n = 1'b1;
                end
                if (w_hs) begin
                    wvalid_n = 1'b0;
                    w_done_n = 1'b1;
                end
                if (aw_done_n && w_done_n) begin
                    state_n   = WR_RESP;
                    bready_n  = 1'b1;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end else if (expired && !aw_hs && !w_hs) begin
                    do_timeout = 1'b1;
                end
            end
            WR_RESP: begin
                if (bvalid && bready) begin
                    state_n     = IDLE;
                    bready_n    = 1'b0;
                    cmd_ready_n = 1'b1;
                    rsp_valid_n = 1'b1;
                    rsp_resp_n  = bresp;
                end else if (expired) begin
                    do_timeout = 1'b1;
                end
            end
            RD_ADDR: begin
                if (arvalid && arready) begin
                    state_n   = RD_DATA;
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                end else if (expired) begin
                    do_timeout = 1'b1;
                end
            end
            RD_DATA: begin
                if (rvalid && rready) begin
                    state_n     = IDLE;
                    rready_n    = 1'b0;
                    cmd_ready_n = 1'b1;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = rdata;
                    rsp_resp_n  = rresp;
                end else if (expired) begin
                    do_timeout = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_timeout) begin
            state_n       = IDLE;
            awvalid_n     = 1'b0;
            wvalid_n      = 1'b0;
            bready_n      = 1'b0;
            arvalid_n     = 1'b0;
            rready_n      = 1'b0;
            aw_done_n     = 1'b0;
            w_done_n      = 1'b0;
            cmd_ready_n   = 1'b1;
            rsp_valid_n   = 1'b1;
            rsp_timeout_n = 1'b1;
            rsp_resp_n    = 2'b10;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            cnt         <= '0;
            cmd_ready   <= 1'b0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
        end else begin
            state       <= state_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            wstrb_q     <= wstrb_n;
            aw_done     <= aw_done_n;
            w_done      <= w_done_n;
            cnt         <= cnt_n;
            cmd_ready   <= cmd_ready_n;
            awvalid     <= awvalid_n;
            wvalid      <= wvalid_n;
            bready      <= bready_n;
            arvalid     <= arvalid_n;
            rready      <= rready_n;
            rsp_valid   <= rsp_valid_n;
            rsp_timeout <= rsp_timeout_n;
            rsp_rdata   <= rsp_rdata_n;
            rsp_resp    <= rsp_resp_n;
        end
    end

endmodule

// File: tb/tb_axi_lite_master_rw.sv
// Directed bench for axi_lite_master_rw: scripted slave timing per transaction, hand-computed
// cycle numbers (accept edge = cycle 0) and response values checked with immediate assertions.
module tb_axi_lite_master_rw;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid, wready = 1'b0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0, bready;
    logic          arvalid, arready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = 2'b00;
    logic          rvalid = 1'b0, rready;
    logic [2:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    // Results captured by run_txn
    int            rsp_cyc, rsp_cnt, aw_last, w_last, b_first;
    logic [DW-1:0] rsp_data_s, bus_wdata;
    logic [1:0]    rsp_resp_s;
    logic          rsp_to_s, rsp_idle_s;
    logic [AW-1:0] bus_addr;
    logic [SW-1:0] bus_wstrb;

    always #5 aclk = ~aclk;

    axi_lite_master_rw #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Issues one command and plays a slave for 40 cycles. A delay of -1 means never ready.
    task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input int aw_dly, input int w_dly,
                           input int r_wait, input logic [1:0] resp, input logic [DW-1:0] rd);
        int aw_hs, w_hs, ar_hs;
        bit b_done, r_done;
        aw_hs = -1; w_hs = -1; ar_hs = -1; b_done = 0; r_done = 0;
        rsp_cyc = -1; rsp_cnt = 0; aw_last = -1; w_last = -1; b_first = -1;
        rsp_data_s = 'x; rsp_resp_s = 'x; rsp_to_s = 1'bx; rsp_idle_s = 1'bx;
        bus_addr = 'x; bus_wdata = 'x; bus_wstrb = 'x;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc < 0) begin
                    rsp_cyc    = n;
                    rsp_data_s = rsp_rdata;
                    rsp_resp_s = rsp_resp;
                    rsp_to_s   = rsp_timeout;
                    rsp_idle_s = !(awvalid || wvalid || bready || arvalid || rready);
                end
            end
            if (awvalid) begin aw_last = n; bus_addr = awaddr; end
            if (wvalid) begin w_last = n; bus_wdata = wdata; bus_wstrb = wstrb; end
            if (arvalid) bus_addr = araddr;
            if (bready && b_first < 0) b_first = n;
            awready = (aw_dly >= 0) && (n > aw_dly);
            wready  = (w_dly >= 0) && (n > w_dly);
            arready = 1'b1;
            bvalid  = (aw_hs > 0) && (w_hs > 0) && !b_done;
            bresp   = resp;
            rvalid  = (ar_hs > 0) && (n >= ar_hs + 1 + r_wait) && !r_done;
            rdata   = rd;
            rresp   = resp;
            if (awvalid && awready) aw_hs = n;
            if (wvalid && wready) w_hs = n;
            if (arvalid && arready) ar_hs = n;
            if (bvalid && bready) b_done = 1;
            if (rvalid && rready) r_done = 1;
            tick();
        end
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = '0;
    endtask

    initial begin
        int acc, nr;
        int rc[4];
        logic [DW-1:0] rdv[4];
        logic [1:0] rrv[4];

        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        check("reset_ctrl", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                             rsp_timeout, rsp_resp, awaddr, araddr, wstrb, dbg_state}, 0);
        check("reset_data", {rsp_rdata, wdata}, 0);
        aresetn = 1'b1;
        check("cmd_ready_before_edge", cmd_ready, 0);
        tick();
        check("cmd_ready_after_release", cmd_ready, 1);

        // Zero-wait write
        run_txn(1, 4'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, '0);
        check("w0_awaddr", bus_addr, 4'h8);
        check("w0_wdata", bus_wdata, 32'hDEADBEEF);
        check("w0_wstrb", bus_wstrb, 4'hF);
        check("w0_rsp_cyc", rsp_cyc, 3);
        check("w0_rsp", {rsp_resp_s, rsp_to_s, rsp_data_s}, 0);
        check("w0_rsp_cnt", rsp_cnt, 1);
        check("w0_valid_drop", {aw_last[7:0], w_last[7:0], b_first[7:0]}, {8'd1, 8'd1, 8'd2});

        // W delayed 5 cycles after AW
        run_txn(1, 4'h4, 32'h0000A5A5, 4'h3, 0, 5, 0, 2'b00, '0);
        check("wdly_aw_last", aw_last, 1);
        check("wdly_w_last", w_last, 6);
        check("wdly_b_first", b_first, 7);
        check("wdly_rsp_cyc", rsp_cyc, 8);
        check("wdly_rsp_cnt", rsp_cnt, 1);
        check("wdly_wstrb", bus_wstrb, 4'h3);

        // AW delayed after W
        run_txn(1, 4'h2, 32'h13572468, 4'h5, 4, 0, 0, 2'b00, '0);
        check("awdly_aw_last", aw_last, 5);
        check("awdly_w_last", w_last, 1);
        check("awdly_b_first", b_first, 6);
        check("awdly_rsp_cyc", rsp_cyc, 7);
        check("awdly_rsp_cnt", rsp_cnt, 1);

        // Read with 3 wait cycles
        run_txn(0, 4'hC, '0, 4'h0, 0, 0, 3, 2'b00, 32'h12345678);
        check("rd_araddr", bus_addr, 4'hC);
        check("rd_rdata", rsp_data_s, 32'h12345678);
        check("rd_resp", {rsp_resp_s, rsp_to_s}, 0);
        check("rd_rsp_cyc", rsp_cyc, 6);
        check("rd_rsp_cnt", rsp_cnt, 1);

        // Error responses
        run_txn(1, 4'h1, 32'hFFFF0000, 4'hC, 0, 0, 0, 2'b10, '0);
        check("slverr_resp", rsp_resp_s, 2'b10);
        check("slverr_to", rsp_to_s, 0);
        check("slverr_rdata", rsp_data_s, 0);
        run_txn(0, 4'h3, '0, 4'h0, 0, 0, 0, 2'b11, 32'hCAFEF00D);
        check("decerr_resp", rsp_resp_s, 2'b11);
        check("decerr_rdata", rsp_data_s, 32'hCAFEF00D);
        check("decerr_cyc", rsp_cyc, 3);

        // Watchdog: awready never comes
        run_txn(1, 4'hA, 32'h0BADF00D, 4'hF, -1, 0, 0, 2'b00, '0);
        check("to_rsp_cyc", rsp_cyc, 17);
        check("to_flags", {rsp_to_s, rsp_resp_s}, 3'b110);
        check("to_rdata", rsp_data_s, 0);
        check("to_rsp_cnt", rsp_cnt, 1);
        check("to_bus_idle", rsp_idle_s, 1);
        check("to_aw_last", aw_last, 16);
        check("to_idle_state", dbg_state, 0);

        // Recovery after timeout
        run_txn(1, 4'h2, 32'h01020304, 4'hF, 0, 0, 0, 2'b00, '0);
        check("post_to_cyc", rsp_cyc, 3);
        check("post_to_rsp", {rsp_to_s, rsp_resp_s}, 0);

        // Reset while waiting for B
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h6; cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 0; awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        check("rst_in_wr_resp", {dbg_state, bready}, {3'd2, 1'b1});
        #2 aresetn = 1'b0;
        #1;
        check("rst_async_ctrl", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                                 rsp_timeout, rsp_resp, awaddr, araddr, wstrb, dbg_state}, 0);
        check("rst_async_data", {rsp_rdata, wdata}, 0);
        tick();
        aresetn = 1'b1;
        check("rst_hold_ready", {cmd_ready, rsp_valid}, 0);
        tick();
        check("rst_release_ready", {cmd_ready, rsp_valid}, 2'b10);
        run_txn(0, 4'h9, '0, 4'h0, 0, 0, 1, 2'b00, 32'h0F0F0F0F);
        check("rst_fresh_rdata", rsp_data_s, 32'h0F0F0F0F);
        check("rst_fresh_cyc", rsp_cyc, 4);

        // Back-to-back alternating write/read with a zero-wait slave
        acc = 0; nr = 0;
        for (int i = 0; i < 4; i++) begin rc[i] = -100; rdv[i] = 'x; rrv[i] = 'x; end
        awready = 1; wready = 1; arready = 1; rdata = 32'h55AA55AA;
        for (int n = 0; n <= 20; n++) begin
            if (rsp_valid) begin
                if (nr < 4) begin rc[nr] = n; rdv[nr] = rsp_rdata; rrv[nr] = rsp_resp; end
                nr++;
            end
            bvalid    = bready;
            rvalid    = rready;
            cmd_valid = (acc < 4);
            cmd_write = (acc[0] == 1'b0);
            cmd_addr  = AW'(acc);
            cmd_wdata = 32'hA0A0_0000 + 32'(acc);
            cmd_wstrb = 4'hF;
            if (cmd_valid && cmd_ready) acc++;
            tick();
        end
        cmd_valid = 0; awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        check("b2b_count", nr, 4);
        check("b2b_first", rc[0], 3);
        check("b2b_gap1", rc[1] - rc[0], 3);
        check("b2b_gap2", rc[2] - rc[1], 3);
        check("b2b_gap3", rc[3] - rc[2], 3);
        check("b2b_rdata", {rdv[0], rdv[1]}, {32'h0, 32'h55AA55AA});
        check("b2b_resp", {rrv[0], rrv[1], rrv[2], rrv[3]}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
